vp_key_event_queue: RTL

Input-side stage directly upstream of vp_keymap. It turns PS/2 key toggle events and gamepad numpad bits into ASCII make/break events and buffers them in a small FIFO. The FIFO is drained through the keymap's rx_data_ready / rx_read handshake. It replaces the ad-hoc single-register ASCII latching, so that simultaneous keys are neither lost nor left stuck.

---
 rtl/vp_key_event_queue_if.sv | 12 +
 rtl/vp_key_event_queue.sv | 94 +++++++++
 2 files changed

// File: rtl/vp_key_event_queue_if.sv
// vp_key_event_queue_if: consumer-side handshake between the key event queue and vp_keymap
interface vp_key_event_queue_if #(parameter int DEPTH = 8);
  localparam int AW = $clog2(DEPTH);
  logic [7:0] ascii_o;
  logic       released_o;
  logic       valid_o;
  logic       ack_i;
  logic [AW:0] fill_o;
  logic       overflow_o;
  modport master (output ascii_o, released_o, valid_o, fill_o, overflow_o, input ack_i);
  modport slave (input ascii_o, released_o, valid_o, fill_o, overflow_o, output ack_i);
endinterface

// File: rtl/vp_key_event_queue.sv
// vp_key_event_queue: PS/2 and gamepad numpad to ASCII make/break FIFO; VP_KEYQ_NUMPAD_EN adds keypad digits
module vp_key_event_queue #(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  input  logic [9:0]  joy_numpad,
  vp_key_event_queue_if.master q
);
  function automatic logic [8:0] base_map(input logic [7:0] c);
    case (c)
      8'h16: return 9'h131; 8'h1E: return 9'h132; 8'h26: return 9'h133; 8'h25: return 9'h134;
      8'h2E: return 9'h135; 8'h36: return 9'h136; 8'h3D: return 9'h137; 8'h3E: return 9'h138;
      8'h46: return 9'h139; 8'h45: return 9'h130;
      8'h1C: return 9'h161; 8'h32: return 9'h162; 8'h21: return 9'h163; 8'h23: return 9'h164;
      8'h24: return 9'h165; 8'h2B: return 9'h166; 8'h34: return 9'h167; 8'h33: return 9'h168;
      8'h43: return 9'h169; 8'h3B: return 9'h16A; 8'h42: return 9'h16B; 8'h4B: return 9'h16C;
      8'h3A: return 9'h16D; 8'h31: return 9'h16E; 8'h44: return 9'h16F; 8'h4D: return 9'h170;
      8'h15: return 9'h171; 8'h2D: return 9'h172; 8'h1B: return 9'h173; 8'h2C: return 9'h174;
      8'h3C: return 9'h175; 8'h2A: return 9'h176; 8'h1D: return 9'h177; 8'h22: return 9'h178;
      8'h35: return 9'h179; 8'h1A: return 9'h17A;
      8'h29: return 9'h120; 8'h79: return 9'h12B; 8'h7B: return 9'h12D; 8'h7C: return 9'h12A;
      8'h4A: return 9'h12F; 8'h55: return 9'h13D;
      8'h1F: return 9'h111; 8'h27: return 9'h112; 8'h5A: return 9'h10A; 8'h66: return 9'h108;
      default: return 9'h000;
    endcase
  endfunction
  logic [8:0] ps2_map;
`ifdef VP_KEYQ_NUMPAD_EN
  function automatic logic [8:0] kp_map(input logic [7:0] c);
    case (c)
      8'h70: return 9'h130; 8'h69: return 9'h131; 8'h72: return 9'h132; 8'h7A: return 9'h133;
      8'h6B: return 9'h134; 8'h73: return 9'h135; 8'h74: return 9'h136; 8'h6C: return 9'h137;
      8'h75: return 9'h138; 8'h7D: return 9'h139;
      default: return 9'h000;
    endcase
  endfunction
  // Extended variants of keypad codes are arrows/navigation and stay unmapped.
  assign ps2_map = base_map(ps2_key[7:0]) | (ps2_key[8] ? 9'h000 : kp_map(ps2_key[7:0]));
`else
  logic unused_ext;
  assign unused_ext = ps2_key[8];
  assign ps2_map = base_map(ps2_key[7:0]);
`endif
  logic [8:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr, rd_next;
  logic [AW:0] fill, fill_pop, fill_next;
  logic        old_toggle, ps2_ev, pop, space, push, push_joy;
  logic [9:0]  joy_reported, diff;
  logic [3:0]  jidx;
  logic [8:0]  joy_entry, wdata, head_next;
  assign ps2_ev = (ps2_key[10] != old_toggle) && ps2_map[8];
  assign diff = joy_numpad ^ joy_reported;
  always_comb begin
    jidx = '0;
    for (int j = 9; j >= 0; j--) if (diff[j]) jidx = 4'(j);
  end
  assign joy_entry = {~joy_numpad[jidx], jidx == 4'd9 ? 8'h30 : 8'h31 + {4'h0, jidx}};
  assign pop = q.ack_i & q.valid_o;
  assign space = fill != (AW+1)'(DEPTH) || pop;
  assign push_joy = !ps2_ev && |diff && space;
  assign push = (ps2_ev && space) || push_joy;
  assign wdata = ps2_ev ? {~ps2_key[9], ps2_map[7:0]} : joy_entry;
  assign fill_pop = fill - (AW+1)'(pop);
  assign fill_next = fill_pop + (AW+1)'(push);
  assign rd_next = rd_ptr + AW'(pop);
  // An entry written into an otherwise empty queue bypasses the array to the head register.
  assign head_next = fill_pop == '0 ? wdata : mem[rd_next];
  assign q.fill_o = fill;
  always_ff @(posedge clk_sys) if (push) mem[wr_ptr] <= wdata;
  always_ff @(posedge clk_sys) begin
    old_toggle <= ps2_key[10];
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      fill <= '0;
      q.valid_o <= 1'b0;
      q.ascii_o <= 8'h00;
      q.released_o <= 1'b0;
      q.overflow_o <= 1'b0;
      joy_reported <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr <= rd_next;
      fill <= fill_next;
      q.valid_o <= fill_next != '0;
      if (fill_next != '0) {q.released_o, q.ascii_o} <= head_next;
      if (ps2_ev && !space) q.overflow_o <= 1'b1;
      if (push_joy) joy_reported[jidx] <= joy_numpad[jidx];
    end
  end
endmodule
